// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, default widths and the master FSM state type.
package axil_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4,
    ST_RSP          = 3'd5
  } axil_mst_state_e;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out, one response back.
// Optional watchdog abort on a stalled AXI wait state when AXIL_MASTER_TIMEOUT_EN is defined.
module axi_lite_master
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH     = AXIL_ADDR_W,
  parameter int DATA_WIDTH     = AXIL_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    A_CLK,
  input  logic                    A_RESET_n,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic                    CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [DATA_WIDTH/8-1:0] CMD_WSTRB,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic [DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]              RSP_RESP,
  output logic [ADDR_WIDTH-1:0]   AW_ADDR,
  output logic                    AW_VALID,
  input  logic                    AW_READY,
  output logic [DATA_WIDTH-1:0]   W_DATA,
  output logic [DATA_WIDTH/8-1:0] W_STRB,
  output logic                    W_VALID,
  input  logic                    W_READY,
  input  logic [1:0]              B_RESP,
  input  logic                    B_VALID,
  output logic                    B_READY,
  output logic [ADDR_WIDTH-1:0]   AR_ADDR,
  output logic                    AR_VALID,
  input  logic                    AR_READY,
  input  logic [DATA_WIDTH-1:0]   R_DATA,
  input  logic [1:0]              R_RESP,
  input  logic                    R_VALID,
  output logic                    R_READY
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  axil_mst_state_e         state_q, state_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  logic                    aw_hs, w_hs;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_st;
`endif

  always_ff @(posedge A_CLK or negedge A_RESET_n) begin
    if (!A_RESET_n) begin
      state_q   <= ST_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
`ifdef AXIL_MASTER_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
`ifdef AXIL_MASTER_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign aw_hs = AW_VALID && AW_READY;
  assign w_hs  = W_VALID && W_READY;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          addr_d    = CMD_ADDR;
          wdata_d   = CMD_WDATA;
          wstrb_d   = CMD_WSTRB;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = CMD_WRITE ? ST_WR_ADDR_DATA : ST_RD_ADDR;
        end
      end
      // AW and W complete independently; each VALID falls once its own handshake is recorded.
      ST_WR_ADDR_DATA: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (B_VALID) begin
          resp_d  = B_RESP;
          rdata_d = '0;
          state_d = ST_RSP;
        end
      end
      ST_RD_ADDR: begin
        if (AR_READY) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (R_VALID) begin
          rdata_d = R_DATA;
          resp_d  = R_RESP;
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (RSP_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
    // A completing handshake wins over the watchdog in the same cycle.
    wait_st = (state_q == ST_WR_ADDR_DATA) || (state_q == ST_WR_RESP) ||
              (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);
    if (wait_st && (state_d == state_q) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
      state_d = ST_RSP;
      resp_d  = RESP_DECERR;
      rdata_d = '0;
    end
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
`endif
  end

  always_comb begin
    CMD_READY = 1'b0;
    AW_VALID  = 1'b0;
    W_VALID   = 1'b0;
    B_READY   = 1'b0;
    AR_VALID  = 1'b0;
    R_READY   = 1'b0;
    RSP_VALID = 1'b0;
    case (state_q)
      ST_IDLE:         CMD_READY = A_RESET_n;
      ST_WR_ADDR_DATA: begin
        AW_VALID = !aw_done_q;
        W_VALID  = !w_done_q;
      end
      ST_WR_RESP:      B_READY   = 1'b1;
      ST_RD_ADDR:      AR_VALID  = 1'b1;
      ST_RD_DATA:      R_READY   = 1'b1;
      ST_RSP:          RSP_VALID = 1'b1;
      default:         CMD_READY = 1'b0;
    endcase
  end

  assign AW_ADDR   = addr_q;
  assign AR_ADDR   = addr_q;
  assign W_DATA    = wdata_q;
  assign W_STRB    = wstrb_q;
  assign RSP_RDATA = rdata_q;
  assign RSP_RESP  = resp_q;

endmodule
